spi_frame_ctrl: RTL

Command sequencer between the SPI slave receiver and the WS2812B frame buffer and output driver. It consumes the received byte stream, decodes one command per chip-select transaction, and streams GRB pixel triplets into frame buffer writes with auto-incrementing, wrapping addresses. It also holds the global brightness register, issues a request/acknowledge "show" handshake to the LED driver, and returns a status byte on the SPI slave's transmit path.

---
 rtl/spi_frame_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - SPI command sequencer feeding the WS2812B frame buffer
//
// Decodes one command per chip-select transaction from the SPI slave byte
// stream, packs GRB pixel triplets into frame buffer writes at an
// auto-incrementing, wrapping address, holds the global brightness register,
// drives the show request/acknowledge handshake and returns a status byte.
//
// Ports:
//   clk         system clock (shared with the SPI slave)
//   reset       synchronous, active-high reset
//   spi_cs      raw chip select, active low; high ends the transaction
//   rx_byte     received byte
//   rx_valid    one-cycle strobe qualifying rx_byte
//   rx_first    rx_byte is the first byte of a transaction (command byte)
//   tx_byte     status {5'b0, err_addr, err_ovr, show_req}
//   fb_we       one-cycle frame buffer write strobe
//   fb_addr     frame buffer write address
//   fb_wdata    pixel data {G,R,B}
//   brightness  global brightness for the driver
//   show_req    request to latch and transmit the frame
//   show_ack    one-cycle driver acknowledge
module spi_frame_ctrl #(
  parameter int         NUM_LEDS   = 64,
  parameter int         ADDR_W     = 6,
  parameter logic [7:0] BRIGHT_RST = 8'h40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              rx_first,
  output logic [7:0]        tx_byte,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_wdata,
  output logic [7:0]        brightness,
  output logic              show_req,
  input  logic              show_ack
);

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_SHOW   = 8'h02;
  localparam logic [7:0] CMD_BRIGHT = 8'h03;
  localparam logic [7:0] CMD_CLRERR = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    PIX_G,
    PIX_R,
    PIX_B,
    BRIGHT,
    DISCARD
  } state_t;

  state_t              state_q;
  logic [7:0]          addr_hi_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [7:0]          g_q;
  logic [7:0]          r_q;
  logic                fb_we_q;
  logic [ADDR_W-1:0]   fb_addr_q;
  logic [23:0]         fb_wdata_q;
  logic [7:0]          bright_q;
  logic                show_req_q;
  logic                err_addr_q;
  logic                err_ovr_q;
  logic [7:0]          tx_byte_q;

  logic                show_req_d;
  logic                err_addr_d;
  logic                err_ovr_d;

  // A raised chip select swallows any byte arriving in the same cycle.
  logic                cmd_v;
  logic                data_v;
  logic [15:0]         addr16;
  logic                addr_oob;
  logic                is_show;
  logic                is_clrerr;

  assign cmd_v     = !spi_cs && rx_valid && rx_first;
  assign data_v    = !spi_cs && rx_valid && !rx_first;
  assign addr16    = {addr_hi_q, rx_byte};
  assign addr_oob  = 32'(addr16) >= NUM_LEDS;
  assign is_show   = cmd_v && (rx_byte == CMD_SHOW);
  assign is_clrerr = cmd_v && (rx_byte == CMD_CLRERR);

  // Flag next-state is computed here so tx_byte can register the same values
  // the flags take, keeping the status byte in step with the flags.
  always_comb begin
    show_req_d = show_req_q;
    err_ovr_d  = err_ovr_q;
    err_addr_d = err_addr_q;
    if (show_ack) begin
      show_req_d = 1'b0;
    end
    if (is_show) begin
      show_req_d = 1'b1;
      // A coincident ack retires the old request, so it is not an overrun.
      if (show_req_q && !show_ack) begin
        err_ovr_d = 1'b1;
      end
    end
    if (data_v && (state_q == ADDR_LO) && addr_oob) begin
      err_addr_d = 1'b1;
    end
    if (is_clrerr) begin
      err_addr_d = 1'b0;
      err_ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_hi_q  <= 8'h00;
      ptr_q      <= '0;
      g_q        <= 8'h00;
      r_q        <= 8'h00;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= 24'h0;
      bright_q   <= BRIGHT_RST;
      show_req_q <= 1'b0;
      err_addr_q <= 1'b0;
      err_ovr_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      fb_we_q    <= 1'b0;
      show_req_q <= show_req_d;
      err_addr_q <= err_addr_d;
      err_ovr_q  <= err_ovr_d;
      tx_byte_q  <= {5'b0, err_addr_d, err_ovr_d, show_req_d};

      if (spi_cs) begin
        // End of transaction; any partial pixel in g_q/r_q is simply dropped.
        state_q <= IDLE;
      end else if (cmd_v) begin
        unique case (rx_byte)
          CMD_WRITE:  state_q <= ADDR_HI;
          CMD_BRIGHT: state_q <= BRIGHT;
          default:    state_q <= DISCARD;
        endcase
      end else if (data_v) begin
        unique case (state_q)
          IDLE: state_q <= DISCARD;
          ADDR_HI: begin
            addr_hi_q <= rx_byte;
            state_q   <= ADDR_LO;
          end
          ADDR_LO: begin
            if (addr_oob) begin
              state_q <= DISCARD;
            end else begin
              ptr_q   <= addr16[ADDR_W-1:0];
              state_q <= PIX_G;
            end
          end
          PIX_G: begin
            g_q     <= rx_byte;
            state_q <= PIX_R;
          end
          PIX_R: begin
            r_q     <= rx_byte;
            state_q <= PIX_B;
          end
          PIX_B: begin
            fb_we_q    <= 1'b1;
            fb_addr_q  <= ptr_q;
            fb_wdata_q <= {g_q, r_q, rx_byte};
            ptr_q      <= (ptr_q == ADDR_W'(NUM_LEDS - 1)) ? '0 : ptr_q + 1'b1;
            state_q    <= PIX_G;
          end
          BRIGHT: begin
            bright_q <= rx_byte;
            state_q  <= DISCARD;
          end
          default: state_q <= DISCARD;
        endcase
      end
    end
  end

  assign tx_byte    = tx_byte_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign brightness = bright_q;
  assign show_req   = show_req_q;

endmodule
